// File: rtl/sfp_master_scheduler.sv
// SFP master-mode link scheduler: services each slave in turn on a fixed period,
// launching its TX frame and collecting the reply frame with a per-slave timeout.
module sfp_master_scheduler #(
  parameter int C_NUMBER_OF_SLAVE = 3,
  parameter int C_DATA_FRAME_BIT  = 384,
  parameter int C_PERIOD_CNT      = 20000,
  parameter int C_TIMEOUT_CNT     = 2000,
  parameter int C_ID_W            = (C_NUMBER_OF_SLAVE > 1) ? $clog2(C_NUMBER_OF_SLAVE) : 1
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_sfp_m_en,
  input  logic [C_DATA_FRAME_BIT*C_NUMBER_OF_SLAVE-1:0] i_tx_stream,
  output logic [C_DATA_FRAME_BIT-1:0]                 o_tx_frame,
  output logic [C_ID_W-1:0]                           o_tx_slave_id,
  output logic                                        o_tx_start,
  input  logic                                        i_rx_end,
  input  logic [C_DATA_FRAME_BIT-1:0]                 i_rx_frame,
  output logic [C_DATA_FRAME_BIT*C_NUMBER_OF_SLAVE-1:0] o_rx_stream,
  output logic [C_NUMBER_OF_SLAVE-1:0]                o_rx_fresh,
  output logic [C_NUMBER_OF_SLAVE-1:0]                o_timeout,
  output logic [15:0]                                 o_timeout_cnt,
  output logic                                        o_overrun,
  output logic                                        o_round_done,
  output logic                                        o_busy
);

  localparam int C_STREAM_W = C_DATA_FRAME_BIT * C_NUMBER_OF_SLAVE;
  localparam int C_PER_W    = $clog2(C_PERIOD_CNT);
  localparam int C_TMR_W    = $clog2(C_TIMEOUT_CNT);
  localparam logic [C_PER_W-1:0] C_PER_LAST = C_PER_W'(C_PERIOD_CNT - 1);
  localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(C_TIMEOUT_CNT - 1);
  localparam logic [C_ID_W-1:0]  C_ID_LAST  = C_ID_W'(C_NUMBER_OF_SLAVE - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_NEXT    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      sat_inc16 = value;
    end else begin
      sat_inc16 = value + 16'd1;
    end
  endfunction

  state_t                      state_r;
  state_t                      state_nx_s;
  logic [C_ID_W-1:0]           idx_r;
  logic [C_PER_W-1:0]          per_cnt_r;
  logic [C_TMR_W-1:0]          tmr_r;
  logic [C_DATA_FRAME_BIT-1:0] tx_frame_r;
  logic [C_ID_W-1:0]           tx_id_r;
  logic                        tx_start_r;
  logic [C_STREAM_W-1:0]       rx_stream_r;
  logic [C_NUMBER_OF_SLAVE-1:0] rx_fresh_r;
  logic [C_NUMBER_OF_SLAVE-1:0] timeout_r;
  logic [15:0]                 timeout_cnt_r;
  logic                        overrun_r;
  logic                        round_done_r;

  logic per_sat_s;
  logic tmr_last_s;
  logic last_slave_s;
  logic launch_s;
  logic store_s;
  logic expire_s;
  logic new_round_s;
  logic advance_s;
  logic done_s;
  logic late_s;

  assign per_sat_s    = (per_cnt_r == C_PER_LAST);
  assign tmr_last_s   = (tmr_r == C_TMR_LAST);
  assign last_slave_s = (idx_r == C_ID_LAST);

  // Next-state decode; a saturated period counter outside HOLD marks the round late
  always_comb begin
    state_nx_s  = state_r;
    launch_s    = 1'b0;
    store_s     = 1'b0;
    expire_s    = 1'b0;
    new_round_s = 1'b0;
    advance_s   = 1'b0;
    done_s      = 1'b0;
    late_s      = 1'b0;
    if (!i_sfp_m_en) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s  = ST_START;
          new_round_s = 1'b1;
        end
        ST_START: begin
          state_nx_s = ST_WAIT_RX;
          launch_s   = 1'b1;
          late_s     = per_sat_s;
        end
        ST_WAIT_RX: begin
          late_s = per_sat_s;
          if (i_rx_end) begin
            store_s    = 1'b1;
            state_nx_s = ST_NEXT;
          end else if (tmr_last_s) begin
            expire_s   = 1'b1;
            state_nx_s = ST_NEXT;
          end else begin
            state_nx_s = ST_WAIT_RX;
          end
        end
        ST_NEXT: begin
          late_s = per_sat_s;
          if (!last_slave_s) begin
            advance_s  = 1'b1;
            state_nx_s = ST_START;
          end else begin
            done_s = 1'b1;
            // A late round skips HOLD and restarts immediately
            if (per_sat_s) begin
              new_round_s = 1'b1;
              state_nx_s  = ST_START;
            end else begin
              state_nx_s = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (per_sat_s) begin
            new_round_s = 1'b1;
            state_nx_s  = ST_START;
          end else begin
            state_nx_s = ST_HOLD;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, slave index, period counter, response timer and strobes
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= {C_ID_W{1'b0}};
      per_cnt_r    <= {C_PER_W{1'b0}};
      tmr_r        <= {C_TMR_W{1'b0}};
      tx_start_r   <= 1'b0;
      round_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      tx_start_r   <= launch_s;
      round_done_r <= done_s;
      if (new_round_s) begin
        idx_r <= {C_ID_W{1'b0}};
      end else if (advance_s) begin
        idx_r <= idx_r + {{(C_ID_W-1){1'b0}}, 1'b1};
      end
      if (new_round_s || (state_nx_s == ST_IDLE)) begin
        per_cnt_r <= {C_PER_W{1'b0}};
      end else if (!per_sat_s) begin
        per_cnt_r <= per_cnt_r + {{(C_PER_W-1){1'b0}}, 1'b1};
      end
      if (launch_s) begin
        tmr_r <= {C_TMR_W{1'b0}};
      end else if ((state_r == ST_WAIT_RX) && (state_nx_s == ST_WAIT_RX)) begin
        tmr_r <= tmr_r + {{(C_TMR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Frame datapath: latch the outgoing frame at launch, store replies into the slave slot
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_frame_r  <= {C_DATA_FRAME_BIT{1'b0}};
      tx_id_r     <= {C_ID_W{1'b0}};
      rx_stream_r <= {C_STREAM_W{1'b0}};
    end else begin
      if (launch_s) begin
        tx_frame_r <= i_tx_stream[int'(idx_r)*C_DATA_FRAME_BIT +: C_DATA_FRAME_BIT];
        tx_id_r    <= idx_r;
      end
      if (store_s) begin
        rx_stream_r[int'(idx_r)*C_DATA_FRAME_BIT +: C_DATA_FRAME_BIT] <= i_rx_frame;
      end
    end
  end

  // Per-slave status flags, timeout statistics and sticky overrun
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_fresh_r    <= {C_NUMBER_OF_SLAVE{1'b0}};
      timeout_r     <= {C_NUMBER_OF_SLAVE{1'b0}};
      timeout_cnt_r <= 16'd0;
      overrun_r     <= 1'b0;
    end else begin
      if (new_round_s) begin
        rx_fresh_r <= {C_NUMBER_OF_SLAVE{1'b0}};
      end else if (store_s) begin
        rx_fresh_r[idx_r] <= 1'b1;
      end
      if (store_s) begin
        timeout_r[idx_r] <= 1'b0;
      end else if (expire_s) begin
        timeout_r[idx_r] <= 1'b1;
        timeout_cnt_r    <= sat_inc16(timeout_cnt_r);
      end
      if (late_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign o_tx_frame    = tx_frame_r;
  assign o_tx_slave_id = tx_id_r;
  assign o_tx_start    = tx_start_r;
  assign o_rx_stream   = rx_stream_r;
  assign o_rx_fresh    = rx_fresh_r;
  assign o_timeout     = timeout_r;
  assign o_timeout_cnt = timeout_cnt_r;
  assign o_overrun     = overrun_r;
  assign o_round_done  = round_done_r;
  assign o_busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sfp_master_scheduler.sv
// Directed bench for sfp_master_scheduler: a long-period instance (a) for normal,
// timeout, disable and reset scenarios, and a short-period instance (b) for overrun.
module tb_sfp_master_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1151:0] tx_stream;
  logic [383:0]  rx_frame;
  logic          en_a, en_b, rx_end_a, rx_end_b;

  logic [383:0]  tx_frame_a, tx_frame_b;
  logic [1:0]    id_a, id_b;
  logic          start_a, start_b;
  logic [1151:0] rx_stream_a, rx_stream_b;
  logic [2:0]    fresh_a, fresh_b, tmo_a, tmo_b;
  logic [15:0]   tcnt_a, tcnt_b;
  logic          ovr_a, ovr_b, done_a, done_b, busy_a, busy_b;

  sfp_master_scheduler #(.C_NUMBER_OF_SLAVE(3), .C_DATA_FRAME_BIT(384),
                         .C_PERIOD_CNT(100), .C_TIMEOUT_CNT(20)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_sfp_m_en(en_a), .i_tx_stream(tx_stream),
    .o_tx_frame(tx_frame_a), .o_tx_slave_id(id_a), .o_tx_start(start_a),
    .i_rx_end(rx_end_a), .i_rx_frame(rx_frame), .o_rx_stream(rx_stream_a),
    .o_rx_fresh(fresh_a), .o_timeout(tmo_a), .o_timeout_cnt(tcnt_a),
    .o_overrun(ovr_a), .o_round_done(done_a), .o_busy(busy_a));

  sfp_master_scheduler #(.C_NUMBER_OF_SLAVE(3), .C_DATA_FRAME_BIT(384),
                         .C_PERIOD_CNT(30), .C_TIMEOUT_CNT(20)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_sfp_m_en(en_b), .i_tx_stream(tx_stream),
    .o_tx_frame(tx_frame_b), .o_tx_slave_id(id_b), .o_tx_start(start_b),
    .i_rx_end(rx_end_b), .i_rx_frame(rx_frame), .o_rx_stream(rx_stream_b),
    .o_rx_fresh(fresh_b), .o_timeout(tmo_b), .o_timeout_cnt(tcnt_b),
    .o_overrun(ovr_b), .o_round_done(done_b), .o_busy(busy_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [383:0] fr_a, fr_b, fr_c, fr_d, fr_e, fr_f, fr_junk, tx0, tx1, tx2;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fr(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [383:0] slot_a(input int k);
    return rx_stream_a[k*384 +: 384];
  endfunction

  task automatic respond_a(input logic [383:0] f, input int dly);
    repeat (dly) tick();
    rx_frame = f;
    rx_end_a = 1'b1;
    tick();
    rx_end_a = 1'b0;
  endtask

  task automatic wait_start(input bit use_b, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(use_b ? start_b : start_a) && n < 150);
  endtask

  initial begin
    int n, s0, s1, nst;
    fr_a    = {6{64'hAAAA_AAAA_AAAA_AAA1}};
    fr_b    = {6{64'hBBBB_BBBB_BBBB_BBB2}};
    fr_c    = {6{64'hCCCC_CCCC_CCCC_CCC3}};
    fr_d    = {6{64'hDDDD_DDDD_DDDD_DDD4}};
    fr_e    = {6{64'hEEEE_EEEE_EEEE_EEE5}};
    fr_f    = {6{64'hF0F0_F0F0_F0F0_F0F6}};
    fr_junk = {6{64'h1234_5678_9ABC_DEF0}};
    tx0 = {48{8'h30}};
    tx1 = {48{8'h31}};
    tx2 = {48{8'h32}};
    tx_stream = {tx2, tx1, tx0};
    rx_frame = 384'd0;
    en_a = 1'b0; en_b = 1'b0; rx_end_a = 1'b0; rx_end_b = 1'b0;
    rst = 1'b0;
    tick(); tick();
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_start", start_a, 1'b0);
    chk("rst_fresh", fresh_a, 3'b000);
    chk("rst_tcnt", tcnt_a, 16'd0);
    chk("rst_ovr_b", ovr_b, 1'b0);
    rst = 1'b1;
    tick();

    // Round 1: every slave answers 5 clocks after its start
    en_a = 1'b1;
    wait_start(1'b0, n);
    s0 = cyc;
    chk("r1_lat0", n, 2);
    chk("r1_id0", id_a, 2'd0);
    chk_fr("r1_frame0", tx_frame_a, tx0);
    respond_a(fr_a, 5);
    wait_start(1'b0, n);
    chk("r1_lat1", n, 2);
    chk("r1_id1", id_a, 2'd1);
    chk_fr("r1_frame1", tx_frame_a, tx1);
    respond_a(fr_b, 5);
    wait_start(1'b0, n);
    chk("r1_id2", id_a, 2'd2);
    respond_a(fr_c, 5);
    chk("r1_done_pre", done_a, 1'b0);
    tick();
    chk("r1_done", done_a, 1'b1);
    chk("r1_fresh", fresh_a, 3'b111);
    chk_fr("r1_slot0", slot_a(0), fr_a);
    chk_fr("r1_slot1", slot_a(1), fr_b);
    chk_fr("r1_slot2", slot_a(2), fr_c);
    chk("r1_ovr", ovr_a, 1'b0);
    // Spurious reply while holding for the period
    rx_frame = fr_junk;
    rx_end_a = 1'b1;
    tick();
    rx_end_a = 1'b0;
    chk("hold_done_once", done_a, 1'b0);
    chk_fr("hold_slot1", slot_a(1), fr_b);
    chk("hold_fresh", fresh_a, 3'b111);
    chk("hold_busy", busy_a, 1'b1);

    // Round 2: slave 1 never answers
    wait_start(1'b0, n);
    s1 = cyc;
    chk("r2_period", s1 - s0, 100);
    chk("r2_id0", id_a, 2'd0);
    chk("r2_fresh_clr", fresh_a, 3'b000);
    respond_a(fr_d, 5);
    wait_start(1'b0, n);
    chk("r2_id1", id_a, 2'd1);
    wait_start(1'b0, n);
    chk("r2_tmo_lat", n, 22);
    chk("r2_id2", id_a, 2'd2);
    chk("r2_tmo", tmo_a, 3'b010);
    chk("r2_tcnt", tcnt_a, 16'd1);
    respond_a(fr_e, 5);
    tick();
    chk("r2_done", done_a, 1'b1);
    chk("r2_fresh", fresh_a, 3'b101);
    chk_fr("r2_slot0", slot_a(0), fr_d);
    chk_fr("r2_slot1_kept", slot_a(1), fr_b);
    chk_fr("r2_slot2", slot_a(2), fr_e);

    // Round 3: slave 0 answers on the timer-expiry cycle, then en drops in slave 1
    wait_start(1'b0, n);
    chk("r3_period", cyc - s1, 100);
    respond_a(fr_f, 19);
    wait_start(1'b0, n);
    chk("r3_lat1", n, 2);
    chk("r3_id1", id_a, 2'd1);
    chk("r3_tmo", tmo_a, 3'b010);
    chk("r3_tcnt", tcnt_a, 16'd1);
    chk_fr("r3_slot0", slot_a(0), fr_f);
    repeat (3) tick();
    en_a = 1'b0;
    tick();
    chk("dis_busy", busy_a, 1'b0);
    chk("dis_start", start_a, 1'b0);
    nst = 0;
    rx_frame = fr_junk;
    rx_end_a = 1'b1;
    tick();
    rx_end_a = 1'b0;
    nst += int'(start_a);
    for (int i = 0; i < 8; i++) begin
      tick();
      nst += int'(start_a);
    end
    chk("dis_no_start", nst, 0);
    chk("dis_busy2", busy_a, 1'b0);
    chk_fr("dis_slot0", slot_a(0), fr_f);
    chk_fr("dis_slot1", slot_a(1), fr_b);
    chk("dis_fresh", fresh_a, 3'b001);
    chk("dis_tmo", tmo_a, 3'b010);
    chk("dis_tcnt", tcnt_a, 16'd1);
    en_a = 1'b1;
    wait_start(1'b0, n);
    chk("re_lat", n, 2);
    chk("re_id", id_a, 2'd0);
    chk("re_fresh", fresh_a, 3'b000);

    // Asynchronous reset in the middle of WAIT_RX, checked before any clock edge
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", busy_a, 1'b0);
    chk("ar_start", start_a, 1'b0);
    chk("ar_id", id_a, 2'd0);
    chk_fr("ar_frame", tx_frame_a, 384'd0);
    chk_fr("ar_slot0", slot_a(0), 384'd0);
    chk("ar_tmo", tmo_a, 3'b000);
    chk("ar_tcnt", tcnt_a, 16'd0);
    chk("ar_fresh", fresh_a, 3'b000);
    en_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Instance b: every slave times out and the round overruns its period
    en_b = 1'b1;
    wait_start(1'b1, n);
    chk("ov_lat0", n, 2);
    chk("ov_id0", id_b, 2'd0);
    wait_start(1'b1, n);
    chk("ov_lat1", n, 22);
    wait_start(1'b1, n);
    chk("ov_lat2", n, 22);
    chk("ov_id2", id_b, 2'd2);
    chk("ov_flag", ovr_b, 1'b1);
    repeat (21) tick();
    chk("ov_done", done_b, 1'b1);
    chk("ov_nostart", start_b, 1'b0);
    tick();
    chk("ov_restart", start_b, 1'b1);
    chk("ov_restart_id", id_b, 2'd0);
    chk("ov_tmo", tmo_b, 3'b111);
    chk("ov_tcnt", tcnt_b, 16'd3);
    repeat (5) tick();
    chk("ov_sticky", ovr_b, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfp_master_scheduler.md
Name: sfp_master_scheduler

Overview:
- Sequences the SFP (Aurora) link when the board is SFP master.
- Services slaves round-robin on a fixed period. For each slave it selects that slave's TX frame, pulses the TX start flag, waits for the RX end flag (with timeout), and stores the returned frame in that slave's RX slot.
- Sits between the AXI register block (TX stream source, RX stream sink) and the Aurora TX/RX framers.

Parameters:
- C_NUMBER_OF_SLAVE, 3, number of slaves serviced per round (1..8).
- C_DATA_FRAME_BIT, 384, bits per slave frame (6 x 64).
- C_PERIOD_CNT, 20000, clocks between round starts (>= 2).
- C_TIMEOUT_CNT, 2000, clocks allowed per slave for i_rx_end after o_tx_start (>= 2).
- C_ID_W, max(1,$clog2(C_NUMBER_OF_SLAVE)), slave id width (derived).

Ports:
- i_clk  in  1  system clock (AXI clock domain).
- i_rst  in  1  asynchronous, active-low reset.
- i_sfp_m_en  in  1  master-mode enable; level.
- i_tx_stream  in  C_DATA_FRAME_BIT*C_NUMBER_OF_SLAVE  TX frames; slave k occupies bits [k*FRAME +: FRAME].
- o_tx_frame  out  C_DATA_FRAME_BIT  frame for the current slave.
- o_tx_slave_id  out  C_ID_W  current slave index.
- o_tx_start  out  1  one-clock start pulse to the Aurora TX.
- i_rx_end  in  1  one-clock RX-complete pulse from the Aurora RX.
- i_rx_frame  in  C_DATA_FRAME_BIT  received frame; valid in the cycle i_rx_end is high.
- o_rx_stream  out  C_DATA_FRAME_BIT*C_NUMBER_OF_SLAVE  stored RX frames, same packing as TX.
- o_rx_fresh  out  C_NUMBER_OF_SLAVE  bit k = slot k updated during the current/last round.
- o_timeout  out  C_NUMBER_OF_SLAVE  bit k = slave k timed out during the last attempt.
- o_timeout_cnt  out  16  total timeouts, saturating at 0xFFFF.
- o_overrun  out  1  sticky: a round was still running when its period elapsed.
- o_round_done  out  1  one-clock pulse when the last slave of a round is finished.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst=0, asynchronous): all outputs and internal registers are 0, state = IDLE.
- States:
  - IDLE: period counter = 0.
  - START: o_tx_start is asserted on the following cycle.
  - WAIT_RX: timer runs.
  - NEXT: advance slave index or end the round.
  - HOLD: wait for the period to elapse.
- IDLE -> START when i_sfp_m_en=1. Slave index = 0, o_rx_fresh cleared, period counter reset to 0.
- START:
  - Register o_tx_frame = i_tx_stream slice[idx] and o_tx_slave_id = idx.
  - Assert o_tx_start for exactly one cycle; frame and id are valid in that same cycle and held until the next start.
  - First o_tx_start occurs 2 clocks after i_sfp_m_en is sampled high.
  - Next state is WAIT_RX, with the timer at 0.
- WAIT_RX:
  - On i_rx_end=1: store i_rx_frame into slot idx, set o_rx_fresh[idx], clear o_timeout[idx], go to NEXT.
  - If the timer reaches C_TIMEOUT_CNT-1 with no i_rx_end: set o_timeout[idx], increment o_timeout_cnt (saturating), leave slot idx unchanged, go to NEXT.
  - i_rx_end in the same cycle as timer expiry counts as a reception; no timeout is recorded.
- NEXT:
  - If idx < C_NUMBER_OF_SLAVE-1: idx+1, go to START.
  - Otherwise: pulse o_round_done, go to HOLD.
- HOLD: when the period counter reaches C_PERIOD_CNT-1, go to START with idx=0, clear o_rx_fresh and the period counter.
- Period counter:
  - Free-runs from each round start and saturates at C_PERIOD_CNT-1.
  - If it saturates before the round reaches HOLD: set o_overrun (sticky until reset), finish the round, then NEXT goes straight to START (no HOLD cycle).
- i_rx_end outside WAIT_RX is ignored: no store, no flag.
- i_sfp_m_en=0 in any state: go to IDLE on the next clock.
  - o_tx_start is forced 0 in that cycle.
  - A pending start pulse is not emitted.
  - o_rx_stream, o_timeout, o_timeout_cnt, o_overrun and o_tx_frame are retained.
  - Re-enabling starts a fresh round at slave 0.
- o_busy = (state != IDLE). Combinational from the state register.
- All other outputs are registered.

Test Plan:
1. Use C_NUMBER_OF_SLAVE=3, C_PERIOD_CNT=100, C_TIMEOUT_CNT=20. Raise en; model answers each start with i_rx_end 5 clocks later, frames 0xA..,0xB..,0xC.. -> o_tx_start 2 clocks after en, o_tx_slave_id 0,1,2, o_rx_stream slots = A,B,C, o_rx_fresh=3'b111, o_round_done once, next slave-0 start exactly 100 clocks after the first.
2. Slave 1 never answers -> o_tx_start for slave 2 occurs 20+2 clocks after slave 1's start, o_timeout=3'b010, o_timeout_cnt=1, slot 1 unchanged, o_rx_fresh=3'b101.
3. i_rx_end coincides with the timer-expiry cycle for slave 0 -> frame stored, o_timeout[0]=0, o_timeout_cnt unchanged.
4. C_PERIOD_CNT=30 and every slave times out (needs ~66 clocks) -> o_overrun=1 stays set, slave-0 start follows o_round_done with no HOLD cycle.
5. Drop en during WAIT_RX of slave 1, restore after 10 clocks -> no further o_tx_start, o_busy=0 the clock after the drop, stored data kept, restart at slave id 0 with o_rx_fresh cleared.
6. Spurious i_rx_end in IDLE and HOLD, plus async reset asserted mid-WAIT_RX -> spurious pulses produce no state or data change; reset clears all outputs immediately with no clock.
